// File: rtl/tow_referee_if.sv
// Signal bundle between the tug-of-war referee and its surroundings:
// raw key levels and playfield win flags in, press pulses, serve
// control, scores and match result out.
interface tow_referee_if;
    // key and playfield side
    logic       left_raw;
    logic       right_raw;
    logic       left_win;
    logic       right_win;

    // referee results
    logic       left_press;
    logic       right_press;
    logic       field_reset;
    logic [2:0] left_score;
    logic [2:0] right_score;
    logic       match_over;
    logic [1:0] winner;

    // drives keys and win flags, observes the referee
    modport master (
        output left_raw, right_raw, left_win, right_win,
        input  left_press, right_press, field_reset,
        input  left_score, right_score, match_over, winner
    );

    // the referee itself
    modport slave (
        input  left_raw, right_raw, left_win, right_win,
        output left_press, right_press, field_reset,
        output left_score, right_score, match_over, winner
    );
endinterface

// File: rtl/tow_referee.sv
// Tug-of-war match controller: edge-detects and arbitrates key presses,
// gates them by game phase, keeps round scores, pauses and re-serves the
// playfield between rounds and declares the first player to WIN_SCORE.
module tow_referee #(
    parameter int WIN_SCORE   = 3,  // 1..7
    parameter int HOLD_CYCLES = 4   // 1..255
) (
    input  logic          clk,
    input  logic          reset,
    tow_referee_if.slave  bus
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] WIN_LIMIT  = 3'(WIN_SCORE);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b10;
    localparam logic [1:0] WINNER_RIGHT = 2'b01;

    // registered state
    state_t     state;
    logic       left_prev;
    logic       right_prev;
    logic [7:0] hold_cnt;
    logic       left_press_q;
    logic       right_press_q;
    logic       field_reset_q;
    logic [2:0] left_score_q;
    logic [2:0] right_score_q;
    logic       match_over_q;
    logic [1:0] winner_q;

    // next-state values
    state_t     state_nx;
    logic [7:0] hold_cnt_nx;
    logic       left_press_nx;
    logic       right_press_nx;
    logic [2:0] left_score_nx;
    logic [2:0] right_score_nx;
    logic       match_over_nx;
    logic [1:0] winner_nx;

    // press arbitration
    logic       left_rise;
    logic       right_rise;
    logic       left_fwd;
    logic       right_fwd;
    logic [2:0] left_inc;
    logic [2:0] right_inc;

    // Rising edges against the previous sample; a simultaneous pair is a tie and both are dropped.
    always_comb begin
        left_rise  = bus.left_raw  & ~left_prev;
        right_rise = bus.right_raw & ~right_prev;
        left_fwd   = left_rise  & ~right_rise;
        right_fwd  = right_rise & ~left_rise;
        left_inc   = left_score_q  + 3'd1;
        right_inc  = right_score_q + 3'd1;
    end

    // Phase sequencing, scoring and press gating.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a value unassigned and infers a latch.
        state_nx       = state;
        hold_cnt_nx    = hold_cnt;
        left_press_nx  = 1'b0;
        right_press_nx = 1'b0;
        left_score_nx  = left_score_q;
        right_score_nx = right_score_q;
        match_over_nx  = match_over_q;
        winner_nx      = winner_q;

        case (state)
            SERVE: begin
                state_nx = PLAY;
            end

            PLAY: begin
                if (bus.left_win || bus.right_win) begin
                    // a win ends the round; any press edge this cycle is dropped
                    hold_cnt_nx = 8'd0;
                    state_nx    = HOLD;
                    if (bus.left_win && !bus.right_win) begin
                        left_score_nx = left_inc;
                        if (left_inc == WIN_LIMIT) begin
                            state_nx      = DONE;
                            match_over_nx = 1'b1;
                            winner_nx     = WINNER_LEFT;
                        end
                    end else if (bus.right_win && !bus.left_win) begin
                        right_score_nx = right_inc;
                        if (right_inc == WIN_LIMIT) begin
                            state_nx      = DONE;
                            match_over_nx = 1'b1;
                            winner_nx     = WINNER_RIGHT;
                        end
                    end
                    // both wins together: scores untouched, round replayed
                end else begin
                    left_press_nx  = left_fwd;
                    right_press_nx = right_fwd;
                end
            end

            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = SERVE;
                end else begin
                    hold_cnt_nx = hold_cnt + 8'd1;
                end
            end

            DONE: begin
                state_nx = DONE;
            end

            default: begin
                state_nx = SERVE;
            end
        endcase
    end

    // State and output registers; reset outranks every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state         <= SERVE;
            left_prev     <= 1'b1;
            right_prev    <= 1'b1;
            hold_cnt      <= 8'd0;
            left_press_q  <= 1'b0;
            right_press_q <= 1'b0;
            field_reset_q <= 1'b1;
            left_score_q  <= 3'd0;
            right_score_q <= 3'd0;
            match_over_q  <= 1'b0;
            winner_q      <= WINNER_NONE;
        end else begin
            state         <= state_nx;
            left_prev     <= bus.left_raw;
            right_prev    <= bus.right_raw;
            hold_cnt      <= hold_cnt_nx;
            left_press_q  <= left_press_nx;
            right_press_q <= right_press_nx;
            field_reset_q <= (state_nx == SERVE);
            left_score_q  <= left_score_nx;
            right_score_q <= right_score_nx;
            match_over_q  <= match_over_nx;
            winner_q      <= winner_nx;
        end
    end

    assign bus.left_press  = left_press_q;
    assign bus.right_press = right_press_q;
    assign bus.field_reset = field_reset_q;
    assign bus.left_score  = left_score_q;
    assign bus.right_score = right_score_q;
    assign bus.match_over  = match_over_q;
    assign bus.winner      = winner_q;

endmodule
